// File: rtl/acc_stack_unit.sv
// acc_stack_unit
//   WIDTH-bit accumulator with a valid/ready operation port and a DEPTH-entry
//   LIFO save stack for spilling and restoring the accumulator.
//   Single-cycle ops: LOAD, ADD, SUB, AND, XOR, PUSH, POP.
//   MUL is an unsigned shift-add that consumes one multiplier bit per cycle.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   : ADD/MUL clamp to all-ones on overflow, SUB clamps to zero on
//               borrow. carry is set the same way as in wrap mode.
//   undefined : every result wraps modulo 2^WIDTH.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   op_valid  in   operation request
//   op        in   3-bit opcode (LOAD ADD SUB AND XOR MUL PUSH POP)
//   data_in   in   WIDTH-bit operand
//   op_ready  out  unit can accept an op this cycle
//   data_out  out  accumulator value
//   carry     out  carry / borrow / multiply-overflow flag
//   zero      out  data_out == 0
//   stk_full  out  stack holds DEPTH entries
//   stk_empty out  stack holds no entries
//   err       out  sticky stack-misuse flag (cleared only by rst)
module acc_stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic             op_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             err
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(WIDTH);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     acc_r, acc_s;
  logic                 carry_r, carry_s;
  logic                 err_r, err_s;
  logic [SPW-1:0]       sp_r, sp_s;
  logic [WIDTH-1:0]     stack_r [DEPTH];

  // Multiplier working registers: the multiplicand shifts left while the
  // multiplier shifts right, so bit 0 of mplier_r is always the current bit.
  logic [2*WIDTH-1:0]   mcand_r, mcand_s;
  logic [WIDTH-1:0]     mplier_r, mplier_s;
  logic [2*WIDTH-1:0]   prod_r, prod_s;
  logic [CW-1:0]        cnt_r, cnt_s;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH-1:0]   partial_s;
  logic [WIDTH-1:0]     add_res_s;
  logic [WIDTH-1:0]     sub_res_s;
  logic [WIDTH-1:0]     mul_res_s;
  logic                 mul_hi_nz_s;
  logic [SPW-1:0]       sp_dec_s;
  logic                 push_we_s;
  logic [IDXW-1:0]      push_idx_s;
  logic [IDXW-1:0]      pop_idx_s;

  // Arithmetic helpers and the wrap / saturate result selection.
  always_comb begin
    sum_s       = {1'b0, acc_r} + {1'b0, data_in};
    diff_s      = {1'b0, acc_r} - {1'b0, data_in};
    partial_s   = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    mul_hi_nz_s = |partial_s[2*WIDTH-1:WIDTH];
    sp_dec_s    = sp_r - {{(SPW-1){1'b0}}, 1'b1};
    push_idx_s  = sp_r[IDXW-1:0];
    pop_idx_s   = sp_dec_s[IDXW-1:0];
`ifdef ACC_SATURATE_EN
    add_res_s = sum_s[WIDTH]  ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
    sub_res_s = diff_s[WIDTH] ? {WIDTH{1'b0}} : diff_s[WIDTH-1:0];
    mul_res_s = mul_hi_nz_s   ? {WIDTH{1'b1}} : partial_s[WIDTH-1:0];
`else
    add_res_s = sum_s[WIDTH-1:0];
    sub_res_s = diff_s[WIDTH-1:0];
    mul_res_s = partial_s[WIDTH-1:0];
`endif
  end

  // Next-state and next-datapath decode for both FSM states.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    carry_s   = carry_r;
    err_s     = err_r;
    sp_s      = sp_r;
    mcand_s   = mcand_r;
    mplier_s  = mplier_r;
    prod_s    = prod_r;
    cnt_s     = cnt_r;
    push_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_LOAD: acc_s = data_in;
            OP_ADD: begin
              acc_s   = add_res_s;
              carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
              acc_s   = sub_res_s;
              carry_s = diff_s[WIDTH];
            end
            OP_AND: acc_s = acc_r & data_in;
            OP_XOR: acc_s = acc_r ^ data_in;
            OP_MUL: begin
              mcand_s  = {{WIDTH{1'b0}}, acc_r};
              mplier_s = data_in;
              prod_s   = {(2*WIDTH){1'b0}};
              cnt_s    = {CW{1'b0}};
              state_s  = ST_MUL;
            end
            OP_PUSH: begin
              if (sp_r == SPW'(DEPTH)) begin
                err_s = 1'b1;
              end else begin
                push_we_s = 1'b1;
                sp_s      = sp_r + {{(SPW-1){1'b0}}, 1'b1};
              end
            end
            OP_POP: begin
              if (sp_r == {SPW{1'b0}}) begin
                err_s = 1'b1;
              end else begin
                sp_s  = sp_dec_s;
                acc_s = stack_r[pop_idx_s];
              end
            end
            default: acc_s = acc_r;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        prod_s   = partial_s;
        cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // The last bit's partial sum is the full product, written directly.
        if (cnt_r == CW'(WIDTH - 1)) begin
          acc_s   = mul_res_s;
          carry_s = mul_hi_nz_s;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MUL;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Accumulator, flags, stack pointer and multiplier working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      err_r    <= 1'b0;
      sp_r     <= {SPW{1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      acc_r    <= acc_s;
      carry_r  <= carry_s;
      err_r    <= err_s;
      sp_r     <= sp_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      prod_r   <= prod_s;
      cnt_r    <= cnt_s;
    end
  end

  // Stack storage keeps its contents across reset; only sp_r is cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_we_s) begin
      stack_r[push_idx_s] <= acc_r;
    end
  end

  assign op_ready  = (state_r == ST_IDLE);
  assign data_out  = acc_r;
  assign carry     = carry_r;
  assign err       = err_r;
  assign zero      = (acc_r == {WIDTH{1'b0}});
  assign stk_full  = (sp_r == SPW'(DEPTH));
  assign stk_empty = (sp_r == {SPW{1'b0}});

endmodule
